// File: rtl/game_flow_fsm.sv
// Match sequencer: start / countdown / play / win / lose flow, both players'
// health with per-player hit cooldown, and the screen-select flags for the display mux.
module game_flow_fsm #(
    parameter int HEALTH_MAX       = 100,
    parameter int HIT_DAMAGE       = 10,
    parameter int COOLDOWN_FRAMES  = 30,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int END_HOLD_FRAMES  = 300
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       frame_tick_in,
    input  logic       start_btn_in,
    input  logic       player_hit_in,
    input  logic       opponent_hit_in,
    output logic       start_display_out,
    output logic       game_active_out,
    output logic       end_win_out,
    output logic       end_lose_out,
    output logic [7:0] player_health_out,
    output logic [7:0] opponent_health_out,
    output logic [1:0] countdown_out
);

    localparam int FRAME_MAX_A = (COOLDOWN_FRAMES > COUNTDOWN_FRAMES) ? COOLDOWN_FRAMES : COUNTDOWN_FRAMES;
    localparam int FRAME_MAX   = (FRAME_MAX_A > END_HOLD_FRAMES) ? FRAME_MAX_A : END_HOLD_FRAMES;
    localparam int CNT_W       = $clog2(FRAME_MAX) + 1;

    localparam logic [7:0]       HEALTH_INIT = 8'(HEALTH_MAX);
    localparam logic [7:0]       DAMAGE      = 8'(HIT_DAMAGE);
    localparam logic [CNT_W-1:0] CD_LOAD     = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(END_HOLD_FRAMES);
    localparam logic [CNT_W-1:0] THIRD_1     = CNT_W'(COUNTDOWN_FRAMES / 3);
    localparam logic [CNT_W-1:0] THIRD_2     = CNT_W'((2 * COUNTDOWN_FRAMES) / 3);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_PLAY,
        S_WIN,
        S_LOSE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_n;
    logic [CNT_W-1:0] player_cd, player_cd_n;
    logic [CNT_W-1:0] opponent_cd, opponent_cd_n;
    logic [7:0]       player_health_n, opponent_health_n;
    logic             start_prev;
    logic             start_edge;
    logic             player_hit_ok;
    logic             opponent_hit_ok;

    function automatic logic [7:0] sat_sub_damage(input logic [7:0] health);
        return (health > DAMAGE) ? (health - DAMAGE) : 8'd0;
    endfunction

    function automatic logic [CNT_W-1:0] cooldown_step(input logic [CNT_W-1:0] cd, input logic tick);
        return (tick && (cd != '0)) ? (cd - ONE) : cd;
    endfunction

    function automatic logic [1:0] countdown_digit(input logic [CNT_W-1:0] cnt);
        if (cnt < THIRD_1) return 2'd3;
        if (cnt < THIRD_2) return 2'd2;
        return 2'd1;
    endfunction

    assign start_edge = start_btn_in && !start_prev;

    // Cooldown gate uses the pre-decrement value, so a hit on the expiring tick is still rejected.
    assign player_hit_ok   = (state == S_PLAY) && player_hit_in && (player_cd == '0);
    assign opponent_hit_ok = (state == S_PLAY) && opponent_hit_in && (opponent_cd == '0);

    always_comb begin
        state_n           = state;
        frame_cnt_n       = frame_cnt;
        player_cd_n       = player_cd;
        opponent_cd_n     = opponent_cd;
        player_health_n   = player_health_out;
        opponent_health_n = opponent_health_out;

        case (state)
            S_IDLE: begin
                if (start_edge) begin
                    state_n           = S_COUNTDOWN;
                    frame_cnt_n       = '0;
                    player_cd_n       = '0;
                    opponent_cd_n     = '0;
                    player_health_n   = HEALTH_INIT;
                    opponent_health_n = HEALTH_INIT;
                end
            end

            S_COUNTDOWN: begin
                if (frame_tick_in) begin
                    if (frame_cnt == CNT_LAST) begin
                        state_n     = S_PLAY;
                        frame_cnt_n = '0;
                    end else begin
                        frame_cnt_n = frame_cnt + ONE;
                    end
                end
            end

            S_PLAY: begin
                if (player_hit_ok) begin
                    player_health_n = sat_sub_damage(player_health_out);
                    player_cd_n     = CD_LOAD;
                end else begin
                    player_cd_n = cooldown_step(player_cd, frame_tick_in);
                end

                if (opponent_hit_ok) begin
                    opponent_health_n = sat_sub_damage(opponent_health_out);
                    opponent_cd_n     = CD_LOAD;
                end else begin
                    opponent_cd_n = cooldown_step(opponent_cd, frame_tick_in);
                end

                // Decided on the registered healths: the match ends the cycle after the killing hit,
                // and a simultaneous knockout resolves as a loss.
                if (player_health_out == 8'd0) begin
                    state_n     = S_LOSE;
                    frame_cnt_n = '0;
                end else if (opponent_health_out == 8'd0) begin
                    state_n     = S_WIN;
                    frame_cnt_n = '0;
                end
            end

            S_WIN, S_LOSE: begin
                if (start_edge && (frame_cnt == HOLD_END)) begin
                    state_n = S_IDLE;
                end else if (frame_tick_in && (frame_cnt != HOLD_END)) begin
                    frame_cnt_n = frame_cnt + ONE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state               <= S_IDLE;
            frame_cnt           <= '0;
            player_cd           <= '0;
            opponent_cd         <= '0;
            player_health_out   <= HEALTH_INIT;
            opponent_health_out <= HEALTH_INIT;
            start_prev          <= 1'b1;
            start_display_out   <= 1'b1;
            game_active_out     <= 1'b0;
            end_win_out         <= 1'b0;
            end_lose_out        <= 1'b0;
            countdown_out       <= 2'd0;
        end else begin
            state               <= state_n;
            frame_cnt           <= frame_cnt_n;
            player_cd           <= player_cd_n;
            opponent_cd         <= opponent_cd_n;
            player_health_out   <= player_health_n;
            opponent_health_out <= opponent_health_n;
            start_prev          <= start_btn_in;
            // Flags are registered from the next state so they switch on the same edge as the state.
            start_display_out   <= (state_n == S_IDLE) || (state_n == S_COUNTDOWN);
            game_active_out     <= (state_n == S_PLAY);
            end_win_out         <= (state_n == S_WIN);
            end_lose_out        <= (state_n == S_LOSE);
            countdown_out       <= (state_n == S_COUNTDOWN) ? countdown_digit(frame_cnt_n) : 2'd0;
        end
    end

endmodule

// File: tb/tb_game_flow_fsm.sv
// Bench for game_flow_fsm: directed match scenarios plus randomized play, checked
// every cycle against a behavioural model of the match rules.
module tb_game_flow_fsm;

    localparam int HM = 100;
    localparam int DMG = 10;
    localparam int CF = 30;
    localparam int CD = 180;
    localparam int EH = 300;

    localparam int M_IDLE = 0;
    localparam int M_CD   = 1;
    localparam int M_PLAY = 2;
    localparam int M_WIN  = 3;
    localparam int M_LOSE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0, start = 1'b0, phit = 1'b0, ohit = 1'b0;
    logic       sd, ga, win, lose;
    logic [7:0] ph, oh;
    logic [1:0] cdig;

    logic       b_tick = 1'b0, b_start = 1'b0, b_phit = 1'b0, b_ohit = 1'b0;
    logic       b_sd, b_ga, b_win, b_lose;
    logic [7:0] b_ph, b_oh;
    logic [1:0] b_cdig;

    int n_cmp = 0;
    int n_bad = 0;

    int m_mode, m_ph, m_oh, m_pcd, m_ocd, m_fr;
    bit m_prev;

    always #5 clk = ~clk;

    game_flow_fsm #(
        .HEALTH_MAX(HM), .HIT_DAMAGE(DMG), .COOLDOWN_FRAMES(CF),
        .COUNTDOWN_FRAMES(CD), .END_HOLD_FRAMES(EH)
    ) dut (
        .clk_in(clk), .rst_in(rst), .frame_tick_in(tick), .start_btn_in(start),
        .player_hit_in(phit), .opponent_hit_in(ohit),
        .start_display_out(sd), .game_active_out(ga), .end_win_out(win), .end_lose_out(lose),
        .player_health_out(ph), .opponent_health_out(oh), .countdown_out(cdig)
    );

    game_flow_fsm #(
        .HEALTH_MAX(100), .HIT_DAMAGE(30), .COOLDOWN_FRAMES(2),
        .COUNTDOWN_FRAMES(6), .END_HOLD_FRAMES(5)
    ) dut_b (
        .clk_in(clk), .rst_in(rst), .frame_tick_in(b_tick), .start_btn_in(b_start),
        .player_hit_in(b_phit), .opponent_hit_in(b_ohit),
        .start_display_out(b_sd), .game_active_out(b_ga), .end_win_out(b_win), .end_lose_out(b_lose),
        .player_health_out(b_ph), .opponent_health_out(b_oh), .countdown_out(b_cdig)
    );

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int hit_health(input int h);
        return (h > DMG) ? h - DMG : 0;
    endfunction

    // Match rules at edge granularity; end-of-match is judged on the healths held before this edge.
    task automatic model_update();
        bit press;
        int nxt;
        if (!rst) begin
            m_mode = M_IDLE; m_ph = HM; m_oh = HM; m_pcd = 0; m_ocd = 0; m_fr = 0; m_prev = 1'b1;
            return;
        end
        press  = start && !m_prev;
        m_prev = start;
        if (m_mode == M_IDLE) begin
            if (press) begin
                m_mode = M_CD; m_fr = 0; m_ph = HM; m_oh = HM; m_pcd = 0; m_ocd = 0;
            end
        end else if (m_mode == M_CD) begin
            if (tick) begin
                m_fr++;
                if (m_fr == CD) begin m_mode = M_PLAY; m_fr = 0; end
            end
        end else if (m_mode == M_PLAY) begin
            nxt = (m_ph == 0) ? M_LOSE : (m_oh == 0) ? M_WIN : M_PLAY;
            if (phit && m_pcd == 0) begin m_ph = hit_health(m_ph); m_pcd = CF; end
            else if (tick && m_pcd > 0) m_pcd--;
            if (ohit && m_ocd == 0) begin m_oh = hit_health(m_oh); m_ocd = CF; end
            else if (tick && m_ocd > 0) m_ocd--;
            if (nxt != M_PLAY) begin m_mode = nxt; m_fr = 0; end
        end else begin
            if (press && m_fr == EH) m_mode = M_IDLE;
            else if (tick && m_fr < EH) m_fr++;
        end
    endtask

    task automatic compare_all();
        logic [3:0] flags;
        int exp_flags, exp_cd;
        flags = {sd, ga, win, lose};
        exp_flags = ((m_mode == M_IDLE || m_mode == M_CD) ? 8 : 0) + ((m_mode == M_PLAY) ? 4 : 0)
                  + ((m_mode == M_WIN) ? 2 : 0) + ((m_mode == M_LOSE) ? 1 : 0);
        exp_cd = (m_mode == M_CD) ? 3 - (m_fr * 3) / CD : 0;
        check("flags", 32'(flags), exp_flags);
        check("flags_onehot", 32'($onehot(flags)), 1);
        check("player_health", 32'(ph), m_ph);
        check("opponent_health", 32'(oh), m_oh);
        check("countdown", 32'(cdig), exp_cd);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic tick_frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic press_start();
        start = 1'b1; cyc();
        start = 1'b0; cyc();
    endtask

    task automatic bcyc();
        @(posedge clk);
        #1;
    endtask

    task automatic b_frames(input int n);
        for (int i = 0; i < n; i++) begin
            b_tick = 1'b1; bcyc();
            b_tick = 1'b0; bcyc();
        end
    endtask

    initial begin
        // Reset with start held: must not launch a match.
        rst = 1'b0; start = 1'b1;
        cyc(); cyc();
        check("reset_flags", 32'({sd, ga, win, lose}), 8);
        check("reset_player_health", 32'(ph), 100);
        rst = 1'b1;
        cyc(); cyc(); cyc();
        check("held_start_idle", 32'({sd, ga, win, lose}), 8);
        start = 1'b0; cyc(); cyc();
        start = 1'b1; cyc();
        check("countdown_frame0", 32'(cdig), 3);
        start = 1'b0; cyc();
        tick_frames(60);
        check("countdown_frame60", 32'(cdig), 2);
        tick_frames(60);
        check("countdown_frame120", 32'(cdig), 1);
        tick_frames(59);
        check("countdown_frame179_active", 32'(ga), 0);
        tick_frames(1);
        check("play_after_180", 32'({sd, ga, win, lose}), 4);
        check("play_opponent_health", 32'(oh), 100);

        // Ten opponent hits spaced 31 frames.
        for (int k = 1; k <= 10; k++) begin
            ohit = 1'b1; cyc();
            ohit = 1'b0;
            check($sformatf("opp_hit_%0d", k), 32'(oh), 100 - 10 * k);
            if (k < 10) tick_frames(31);
        end
        check("win_not_yet", 32'(win), 0);
        cyc();
        check("win_after_last_hit", 32'(win), 1);
        check("win_player_health", 32'(ph), 100);

        // End-screen hold: early press discarded, late press returns to IDLE with frozen bars.
        tick_frames(100);
        press_start();
        check("early_press_ignored", 32'(win), 1);
        tick_frames(200);
        start = 1'b1; cyc();
        check("hold_press_idle", 32'({sd, ga, win, lose}), 8);
        check("idle_frozen_opp", 32'(oh), 0);
        start = 1'b0; cyc();
        start = 1'b1; cyc();
        check("restart_countdown", 32'(cdig), 3);
        check("restart_opp_reload", 32'(oh), 100);
        start = 1'b0; cyc();

        // Cooldown: hits at relative frames 0, 15, 30.
        tick_frames(180);
        phit = 1'b1; cyc(); phit = 1'b0;
        check("cool_hit0", 32'(ph), 90);
        tick_frames(15);
        phit = 1'b1; cyc(); phit = 1'b0;
        check("cool_hit15_rejected", 32'(ph), 90);
        tick_frames(15);
        phit = 1'b1; cyc(); phit = 1'b0;
        check("cool_hit30_accepted", 32'(ph), 80);
        cyc();

        // Randomized play, restarts and occasional resets.
        for (int i = 0; i < 6000; i++) begin
            rst  = ($urandom_range(0, 2999) != 0);
            tick = ($urandom_range(0, 1) == 1);
            phit = ($urandom_range(0, 11) == 0);
            ohit = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 39) == 0) start = ~start;
            cyc();
        end
        rst = 1'b1; tick = 1'b0; phit = 1'b0; ohit = 1'b0; start = 1'b0;

        // Reset mid-play with 40/70.
        rst = 1'b0; cyc();
        rst = 1'b1; cyc();
        press_start();
        tick_frames(180);
        for (int k = 0; k < 6; k++) begin
            phit = 1'b1; ohit = (k < 3); cyc();
            phit = 1'b0; ohit = 1'b0;
            tick_frames(31);
        end
        check("midplay_player_40", 32'(ph), 40);
        check("midplay_opp_70", 32'(oh), 70);
        check("midplay_active", 32'(ga), 1);
        rst = 1'b0; cyc();
        check("midplay_reset_flags", 32'({sd, ga, win, lose}), 8);
        check("midplay_reset_player", 32'(ph), 100);
        check("midplay_reset_opp", 32'(oh), 100);
        rst = 1'b1; cyc();

        // Second instance: damage 30, simultaneous knockout from 10/10 is a loss.
        b_start = 1'b1; bcyc(); b_start = 1'b0;
        check("b_countdown_entry", 32'({b_sd, b_cdig}), 7);
        b_frames(6);
        check("b_play", 32'(b_ga), 1);
        for (int k = 0; k < 3; k++) begin
            b_phit = 1'b1; b_ohit = 1'b1; bcyc();
            b_phit = 1'b0; b_ohit = 1'b0;
            b_frames(2);
        end
        check("b_player_10", 32'(b_ph), 10);
        check("b_opp_10", 32'(b_oh), 10);
        b_phit = 1'b1; b_ohit = 1'b1; bcyc();
        b_phit = 1'b0; b_ohit = 1'b0;
        check("b_player_0", 32'(b_ph), 0);
        check("b_opp_0", 32'(b_oh), 0);
        bcyc();
        check("b_draw_lose", 32'(b_lose), 1);
        check("b_draw_not_win", 32'(b_win), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
